// File: rtl/ede_seq_ctrl.sv
// Frame sequencer for the 15-tap triangular (1..8..1) smoothing filter: loads a frame into
// an external single-port RAM, then produces one edge-replicated result per sample on a single MAC.
module ede_seq_ctrl #(
  parameter int N_SAMPLES = 2400,
  parameter int DW        = 10,
  parameter int AW        = 12,
  parameter int SW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_HOLD
  } state_t;

  localparam int PW   = AW + 2;  // signed tap position, wide enough for n+k-7 without wrap
  localparam int MW   = DW + 4;
  localparam int HALF = 7;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMPLES - 1);
  localparam logic [3:0]    LAST_K   = 4'd15;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] n;
  logic [3:0]    k;
  logic [3:0]    k_d;
  logic          rd_pend;
  logic [SW-1:0] acc;

  logic signed [PW-1:0] tap_pos;
  logic [AW-1:0]        tap_addr;
  logic [MW-1:0]        product;

  function automatic logic [3:0] coef(input logic [3:0] tap);
    return (tap < 4'd8) ? tap + 4'd1 : 4'd15 - tap;
  endfunction

  // Edge replication: positions before 0 or past the last sample read the end sample.
  assign tap_pos = $signed({2'b00, n}) + $signed({{(PW-4){1'b0}}, k}) - $signed(PW'(HALF));

  always_comb begin
    if (tap_pos[PW-1]) begin
      tap_addr = '0;
    end else if (tap_pos > $signed(PW'(N_SAMPLES - 1))) begin
      tap_addr = LAST_IDX;
    end else begin
      tap_addr = tap_pos[AW-1:0];
    end
  end

  assign product = MW'(mem_rdata) * MW'(coef(k_d));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so that no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        mem_addr = wr_ptr;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_wdata = in_data;
          if (wr_ptr == LAST_IDX) begin
            state_nxt = S_MAC;
          end
        end
      end
      S_MAC: begin
        if (k == LAST_K) begin
          state_nxt = S_HOLD;
        end else begin
          mem_addr = tap_addr;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = (n == LAST_IDX) ? S_IDLE : S_MAC;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: write pointer, sample index, tap counter and the accumulator.
  // The read issued on tap k returns one cycle later, so it is weighted by k_d.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      n       <= '0;
      k       <= '0;
      k_d     <= '0;
      rd_pend <= 1'b0;
      acc     <= '0;
      done    <= 1'b0;
    end else begin
      k_d     <= k;
      rd_pend <= (state == S_MAC) && (k != LAST_K);
      done    <= (state == S_HOLD) && out_ready && (n == LAST_IDX);
      case (state)
        S_IDLE: begin
          if (start) begin
            wr_ptr <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_IDX) begin
              n   <= '0;
              k   <= '0;
              acc <= '0;
            end
          end
        end
        S_MAC: begin
          k <= k + 1'b1;
          if (rd_pend) begin
            acc <= acc + SW'(product);
          end
        end
        S_HOLD: begin
          if (out_ready && (n != LAST_IDX)) begin
            n   <= n + 1'b1;
            k   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign out_data  = acc;
  assign out_index = n;

endmodule

// File: tb/tb_ede_seq_ctrl.sv
// Self-checking bench for ede_seq_ctrl: 20-sample frames, behavioural filter model,
// per-cycle monitor plus directed edge/impulse/latency/reset scenarios.
module tb_ede_seq_ctrl;

  localparam int N  = 20;
  localparam int DW = 10;
  localparam int AW = 12;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] frame [N];
  int            got   [N];
  int            exp_idx  = 0;
  int            wr_count = 0;

  logic [DW-1:0] ram [2**AW];

  ede_seq_ctrl #(.N_SAMPLES(N), .DW(DW), .AW(AW), .SW(SW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port sample RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Triangular weights 8-|j| around the centre, replicating the end samples.
  function automatic int model_out(input int idx);
    int s = 0;
    for (int j = -7; j <= 7; j++) begin
      int p = idx + j;
      if (p < 0) p = 0;
      if (p > N - 1) p = N - 1;
      s += (8 - ((j < 0) ? -j : j)) * int'(frame[p]);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame_books();
    exp_idx  = 0;
    wr_count = 0;
    for (int i = 0; i < N; i++) got[i] = -1;
  endtask

  // Per-cycle compare process, sampling on the falling edge.
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [SW-1:0] prev_data  = '0;
  logic [AW-1:0] prev_index = '0;
  logic          done_exp   = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
      done_exp   = 1'b0;
    end else begin
      check("done_pulse", done, done_exp);
      done_exp = 1'b0;
      check("mem_addr_range", mem_addr <= AW'(N - 1), 1);
      check("write_gate", mem_we, in_valid && in_ready);
      if (!busy) check("in_ready_idle", in_ready, 0);
      if (mem_we) begin
        check("write_addr", mem_addr, wr_count);
        check("write_data", mem_wdata, in_data);
        wr_count++;
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_index", out_index, prev_index);
      end
      if (out_valid) begin
        check("in_ready_in_hold", in_ready, 0);
        if (out_ready) begin
          check("out_index", out_index, exp_idx);
          check("out_data", out_data, model_out(exp_idx));
          if (exp_idx < N) got[exp_idx] = int'(out_data);
          if (exp_idx == N - 1) done_exp = 1'b1;
          exp_idx++;
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_index = out_index;
    end
  end

  // One complete frame from IDLE with random input/output throttling (percent).
  task automatic run_frame(input int pv, input int pr);
    int idx = 0;
    int cyc = 0;
    logic seen_done = 1'b0;
    new_frame_books();
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    while (!seen_done && cyc < 5000) begin
      in_valid  = (idx < N) && ($urandom_range(99) < pv);
      in_data   = in_valid ? frame[idx] : DW'($urandom);
      out_ready = ($urandom_range(99) < pr);
      start     = busy && ($urandom_range(15) == 0);
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
      seen_done = done;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;
    check("frame_done_in_budget", seen_done, 1);
    check("frame_write_count", wr_count, N);
    check("frame_result_count", exp_idx, N);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int idx;
    int first;

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    reset = 1'b1;
    tick();

    // Flat frame at full scale.
    for (int i = 0; i < N; i++) frame[i] = 10'd1023;
    run_frame(100, 100);
    check("flat_out0", got[0], 65472);
    check("flat_out10", got[10], 65472);
    check("flat_out19", got[19], 65472);

    // Impulse at sample 10.
    for (int i = 0; i < N; i++) frame[i] = '0;
    frame[10] = 10'd1;
    run_frame(100, 100);
    check("imp_out2", got[2], 0);
    check("imp_out3", got[3], 1);
    check("imp_out7", got[7], 5);
    check("imp_out10", got[10], 8);
    check("imp_out14", got[14], 4);
    check("imp_out17", got[17], 1);
    check("imp_out18", got[18], 0);

    // Left edge replication.
    for (int i = 0; i < N; i++) frame[i] = '0;
    frame[0] = 10'd100;
    run_frame(100, 100);
    check("left_out0", got[0], 3600);
    check("left_out1", got[1], 2800);
    check("left_out2", got[2], 2100);
    check("left_out7", got[7], 100);
    check("left_out8", got[8], 0);

    // Right edge replication.
    for (int i = 0; i < N; i++) frame[i] = '0;
    frame[N-1] = 10'd100;
    run_frame(100, 100);
    check("right_out19", got[19], 3600);
    check("right_out18", got[18], 2800);
    check("right_out12", got[12], 100);
    check("right_out11", got[11], 0);

    // Latency and backpressure: start in cycle 0, in_valid held high.
    for (int i = 0; i < N; i++) frame[i] = DW'($urandom_range(1023));
    new_frame_books();
    cyc = 0; idx = 0; first = -1;
    start = 1'b1; out_ready = 1'b0;
    while (first < 0 && cyc < 200) begin
      in_valid = (idx < N);
      in_data  = frame[(idx < N) ? idx : 0];
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
      start = 1'b0;
      if (out_valid) first = cyc;
    end
    in_valid = 1'b0;
    check("first_out_valid_cycle", first, 37);
    repeat (5) begin tick(); cyc++; end
    check("stalled_valid", out_valid, 1);
    check("stalled_index", out_index, 0);
    out_ready = 1'b1;
    tick(); cyc++;
    check("valid_drops_after_accept", out_valid, 0);
    while (!out_valid && cyc < 400) begin tick(); cyc++; end
    check("second_out_valid_cycle", cyc, 59);
    while (!done && cyc < 1000) begin tick(); cyc++; end
    check("done_cycle", cyc, 366);
    out_ready = 1'b0;
    check("latency_frame_results", exp_idx, N);

    // Randomized frames with throttled input and output.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++)
        frame[i] = (f == 3) ? (($urandom_range(1) != 0) ? 10'd1023 : 10'd0) : DW'($urandom_range(1023));
      run_frame($urandom_range(30, 100), $urandom_range(30, 100));
    end

    // Reset during MAC of n=5, with start asserted alongside reset.
    for (int i = 0; i < N; i++) frame[i] = DW'($urandom_range(1023));
    new_frame_books();
    cyc = 0; idx = 0;
    start = 1'b1;
    while (!(exp_idx == 5 && !out_valid) && cyc < 1000) begin
      in_valid  = (idx < N);
      in_data   = frame[(idx < N) ? idx : 0];
      out_ready = 1'b1;
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
      start = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("reached_mac_n5", exp_idx, 5);
    reset = 1'b0; start = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_index", out_index, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_mem_addr", mem_addr, 0);
    tick();
    check("reset_beats_start", busy, 0);
    reset = 1'b1; start = 1'b0;
    tick();
    check("idle_after_reset", busy, 0);
    for (int i = 0; i < N; i++) frame[i] = DW'($urandom_range(1023));
    run_frame(70, 70);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
